// File: rtl/core_mem_bridge_pkg.sv
// Shared types and constants for the execute-stage memory bridge.
package core_mem_bridge_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  localparam logic [MEM_ADDR_W-1:0] CPU_RST_ADDRESS = '0;
  localparam logic [MEM_DATA_W-1:0] ZERO_WORD       = '0;

  // Bridge sequencer states
  typedef enum logic [1:0] {
    MEMBR_IDLE = 2'd0,
    MEMBR_RD   = 2'd1,
    MEMBR_WR   = 2'd2,
    MEMBR_DONE = 2'd3
  } membr_state_e;

endpackage

// File: rtl/core_mem_bridge.sv
// Converts the execute stage's same-cycle memory port into a req/ack bus
// transaction, holding the pipeline until data is ready. Stores are done
// as read-modify-write: the read word goes back to the execute stage, which
// merges the store data, and the merged word is then written.
module core_mem_bridge
  import core_mem_bridge_pkg::*;
#(
  parameter int BUS_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_mem_req_in,
  input  logic                  ex_mem_we_in,
  input  logic [MEM_ADDR_W-1:0] ex_mem_addr_in,
  input  logic [MEM_DATA_W-1:0] ex_mem_data_in,
  output logic [MEM_DATA_W-1:0] ex_mem_rdata_out,
  output logic                  hold_flag_out,
  output logic                  bus_req_out,
  output logic                  bus_we_out,
  output logic [MEM_ADDR_W-1:0] bus_addr_out,
  output logic [MEM_DATA_W-1:0] bus_wdata_out,
  input  logic [MEM_DATA_W-1:0] bus_rdata_in,
  input  logic                  bus_ack_in,
  output logic                  bus_err_out
);

  // A zero timeout disables the limit; keep the counter at least one bit wide.
  localparam int TMO_W = (BUS_TIMEOUT > 0) ? $clog2(BUS_TIMEOUT + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = (BUS_TIMEOUT > 0) ? TMO_W'(BUS_TIMEOUT - 1) : '0;
  localparam logic [TMO_W-1:0] TMO_MAX  = '1;

  membr_state_e          state_q, state_d;
  logic [MEM_ADDR_W-1:0] addr_q;
  logic                  we_q;
  logic [MEM_DATA_W-1:0] rdata_q;
  logic [TMO_W-1:0]      tmo_cnt;
  logic                  err_q;
  logic                  tmo_hit;
  logic                  tmo_fire;

  // An ack on the limit cycle takes priority over the timeout.
  assign tmo_hit = (BUS_TIMEOUT != 0) && (tmo_cnt == TMO_LAST) && !bus_ack_in;

  assign ex_mem_rdata_out = rdata_q;
  assign bus_err_out      = err_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= MEMBR_IDLE;
    else     state_q <= state_d;
  end

  // Next-state, bus drive and hold request.
  always_comb begin
    state_d       = state_q;
    bus_req_out   = 1'b0;
    bus_we_out    = 1'b0;
    bus_addr_out  = '0;
    bus_wdata_out = '0;
    hold_flag_out = 1'b0;
    tmo_fire      = 1'b0;
    case (state_q)
      MEMBR_IDLE: begin
        hold_flag_out = ex_mem_req_in;
        if (ex_mem_req_in) state_d = MEMBR_RD;
      end
      MEMBR_RD: begin
        bus_req_out   = 1'b1;
        bus_addr_out  = addr_q;
        hold_flag_out = 1'b1;
        if (bus_ack_in) begin
          state_d = we_q ? MEMBR_WR : MEMBR_DONE;
        end else if (tmo_hit) begin
          state_d  = MEMBR_DONE;
          tmo_fire = 1'b1;
        end
      end
      MEMBR_WR: begin
        bus_req_out   = 1'b1;
        bus_we_out    = 1'b1;
        bus_addr_out  = addr_q;
        // Stable through WR since the merge is against the constant rdata_q.
        bus_wdata_out = ex_mem_data_in;
        hold_flag_out = 1'b1;
        if (bus_ack_in) begin
          state_d = MEMBR_DONE;
        end else if (tmo_hit) begin
          state_d  = MEMBR_DONE;
          tmo_fire = 1'b1;
        end
      end
      MEMBR_DONE: begin
        // Execute stage commits now; never restart on its lingering request.
        state_d = MEMBR_IDLE;
      end
      default: state_d = MEMBR_IDLE;
    endcase
  end

  // Latch the access address and direction when a request is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= CPU_RST_ADDRESS;
      we_q   <= 1'b0;
    end else if (state_q == MEMBR_IDLE && ex_mem_req_in) begin
      addr_q <= ex_mem_addr_in;
      we_q   <= ex_mem_we_in;
    end
  end

  // Capture the read word; a timed-out access returns zero.
  always_ff @(posedge clk) begin
    if (rst)                                   rdata_q <= ZERO_WORD;
    else if (state_q == MEMBR_RD && bus_ack_in) rdata_q <= bus_rdata_in;
    else if (tmo_fire)                         rdata_q <= ZERO_WORD;
  end

  // Saturating per-phase wait counter, cleared on every state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state_d != state_q) begin
      tmo_cnt <= '0;
    end else if ((state_q == MEMBR_RD || state_q == MEMBR_WR) && tmo_cnt != TMO_MAX) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Error pulse lands in the DONE cycle that follows a timeout.
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= tmo_fire;
  end

endmodule

// File: tb/tb_core_mem_bridge.sv
// Randomized bench for core_mem_bridge: acts as both execute stage and bus
// slave, predicting each access from transaction-level rules.
module tb_core_mem_bridge;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_mem_req_in;
  logic        ex_mem_we_in;
  logic [31:0] ex_mem_addr_in;
  logic [31:0] ex_mem_data_in;
  logic [31:0] ex_mem_rdata_out;
  logic        hold_flag_out;
  logic        bus_req_out;
  logic        bus_we_out;
  logic [31:0] bus_addr_out;
  logic [31:0] bus_wdata_out;
  logic [31:0] bus_rdata_in;
  logic        bus_ack_in;
  logic        bus_err_out;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [logic [31:0]];

  always #5 clk = ~clk;

  core_mem_bridge #(.BUS_TIMEOUT(T)) dut (
    .clk              (clk),
    .rst              (rst),
    .ex_mem_req_in    (ex_mem_req_in),
    .ex_mem_we_in     (ex_mem_we_in),
    .ex_mem_addr_in   (ex_mem_addr_in),
    .ex_mem_data_in   (ex_mem_data_in),
    .ex_mem_rdata_out (ex_mem_rdata_out),
    .hold_flag_out    (hold_flag_out),
    .bus_req_out      (bus_req_out),
    .bus_we_out       (bus_we_out),
    .bus_addr_out     (bus_addr_out),
    .bus_wdata_out    (bus_wdata_out),
    .bus_rdata_in     (bus_rdata_in),
    .bus_ack_in       (bus_ack_in),
    .bus_err_out      (bus_err_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_get(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [7:0] b, input int off);
    logic [31:0] r;
    r = old;
    r[off*8 +: 8] = b;
    return r;
  endfunction

  // Idle cycles with no request: no hold, no bus activity, stray acks ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ex_mem_req_in = 1'b0;
      bus_ack_in    = 1'($urandom_range(0, 1));
      bus_rdata_in  = $urandom;
      #1;
      chk("idle_hold", 32'(hold_flag_out), 32'd0);
      chk("idle_req", 32'(bus_req_out), 32'd0);
    end
  endtask

  // One memory instruction; w_rd / w_wr are wait states before each ack.
  task automatic access(input logic we, input logic [31:0] addr, input logic [7:0] sb,
                        input int off, input int w_rd, input int w_wr);
    logic [31:0] old, exp_rdata, exp_wdata;
    bit rd_to, do_wr, wr_to, done;
    int rdc, wrc, exp_hold, exp_reads, exp_writes, exp_err;
    int hold_n, reads, writes, errs, addr_bad, wdata_bad, phase_cnt, prev_phase, cur_phase, wt;
    string nm;

    old        = mem_get(addr);
    rd_to      = (w_rd >= T);
    rdc        = rd_to ? T : w_rd + 1;
    do_wr      = we && !rd_to;
    wr_to      = do_wr && (w_wr >= T);
    wrc        = do_wr ? (wr_to ? T : w_wr + 1) : 0;
    exp_hold   = 1 + rdc + wrc;
    exp_reads  = rd_to ? 0 : 1;
    exp_writes = (do_wr && !wr_to) ? 1 : 0;
    exp_err    = (rd_to || wr_to) ? 1 : 0;
    exp_rdata  = (rd_to || wr_to) ? 32'h0 : old;
    exp_wdata  = merge(old, sb, off);

    hold_n = 0; reads = 0; writes = 0; errs = 0; addr_bad = 0; wdata_bad = 0;
    phase_cnt = 0; prev_phase = -1; done = 0;
    nm = we ? "st" : "ld";

    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      ex_mem_req_in  = 1'b1;
      ex_mem_we_in   = we;
      ex_mem_addr_in = addr;
      ex_mem_data_in = we ? merge(ex_mem_rdata_out, sb, off) : $urandom;
      cur_phase = !bus_req_out ? 0 : (bus_we_out ? 2 : 1);
      if (cur_phase != prev_phase) phase_cnt = 0;
      wt = (cur_phase == 2) ? w_wr : w_rd;
      if (cur_phase == 0) bus_ack_in = 1'($urandom_range(0, 1));
      else                bus_ack_in = (phase_cnt == wt);
      bus_rdata_in = (cur_phase == 1 && bus_ack_in) ? mem_get(bus_addr_out) : $urandom;
      #1;
      if (hold_flag_out) hold_n++;
      if (cur_phase != 0 && bus_addr_out !== addr) addr_bad++;
      if (cur_phase == 1 && bus_ack_in) reads++;
      if (cur_phase == 2 && bus_ack_in) begin
        writes++;
        if (bus_wdata_out !== exp_wdata) wdata_bad++;
        mem[addr] = bus_wdata_out;
      end
      if (bus_err_out) errs++;
      if (!hold_flag_out) begin
        done = 1;
        chk({nm, "_rdata"}, ex_mem_rdata_out, exp_rdata);
        chk({nm, "_done_req"}, 32'(bus_req_out), 32'd0);
      end
      prev_phase = cur_phase;
      phase_cnt++;
    end

    chk({nm, "_commit"}, 32'(done), 32'd1);
    chk({nm, "_hold"}, 32'(hold_n), 32'(exp_hold));
    chk({nm, "_reads"}, 32'(reads), 32'(exp_reads));
    chk({nm, "_writes"}, 32'(writes), 32'(exp_writes));
    chk({nm, "_err"}, 32'(errs), 32'(exp_err));
    chk({nm, "_addr_stable"}, 32'(addr_bad), 32'd0);
    chk({nm, "_wdata"}, 32'(wdata_bad), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=stuck want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ex_mem_req_in = 1'b0; ex_mem_we_in = 1'b0; ex_mem_addr_in = '0; ex_mem_data_in = '0;
    bus_rdata_in = '0; bus_ack_in = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rdata", ex_mem_rdata_out, 32'h0);
    chk("rst_req", 32'(bus_req_out), 32'd0);
    chk("rst_we", 32'(bus_we_out), 32'd0);
    chk("rst_addr", bus_addr_out, 32'h0);
    chk("rst_err", 32'(bus_err_out), 32'd0);
    chk("rst_hold0", 32'(hold_flag_out), 32'd0);
    ex_mem_req_in = 1'b1;
    #1;
    chk("rst_hold1", 32'(hold_flag_out), 32'd1);
    ex_mem_req_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Zero-wait load
    mem[32'h100] = 32'h1234_5678;
    access(1'b0, 32'h100, 8'h00, 0, 0, 0);
    idle(1);

    // Byte store read-modify-write
    mem[32'h104] = 32'hAABB_CCDD;
    access(1'b1, 32'h104, 8'h11, 1, 0, 0);
    chk("sb_mem", mem_get(32'h104), 32'hAABB_11DD);
    idle(1);

    // Load with three wait states (ack lands on the timeout limit cycle)
    access(1'b0, 32'h108, 8'h00, 0, 3, 0);
    idle(1);

    // Store that never gets an ack
    mem[32'h10C] = 32'h0BAD_F00D;
    access(1'b1, 32'h10C, 8'h77, 2, 9, 0);
    chk("tmo_mem", mem_get(32'h10C), 32'h0BAD_F00D);
    idle(1);

    // Reset in the second RD wait cycle
    @(negedge clk);
    ex_mem_req_in = 1'b1; ex_mem_we_in = 1'b1; ex_mem_addr_in = 32'h300; bus_ack_in = 1'b0;
    @(negedge clk);
    bus_ack_in = 1'b0;
    #1;
    chk("rd_req", 32'(bus_req_out), 32'd1);
    @(negedge clk);
    bus_ack_in = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ex_mem_req_in = 1'b0;
    #1;
    chk("rstab_req", 32'(bus_req_out), 32'd0);
    chk("rstab_hold0", 32'(hold_flag_out), 32'd0);
    chk("rstab_rdata", ex_mem_rdata_out, 32'h0);
    ex_mem_req_in = 1'b1;
    #1;
    chk("rstab_hold1", 32'(hold_flag_out), 32'd1);
    ex_mem_req_in = 1'b0;
    idle(2);

    // Back-to-back loads
    mem[32'h200] = 32'h2000_0001;
    mem[32'h204] = 32'h2040_0002;
    access(1'b0, 32'h200, 8'h00, 0, 0, 0);
    access(1'b0, 32'h204, 8'h00, 0, 1, 0);
    idle(1);

    // Randomized mix of loads, stores, wait states and timeouts
    for (int i = 0; i < 40; i++) begin
      access(1'($urandom_range(0, 1)), 32'h400 + {26'($urandom_range(0, 15)), 2'b00},
             8'($urandom), $urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 5));
      idle($urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
